// File: rtl/vedic_seq_mul_ctrl_if.sv
// Operand/result handshake bundle for the sequential vedic multiplier controller.
// The master side is the operand source plus result sink; the slave side is the controller.
interface vedic_seq_mul_ctrl_if #(
  parameter int NIB = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [4*NIB-1:0]   a;
  logic [4*NIB-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [8*NIB-1:0]   p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/vedic_seq_mul_ctrl.sv
// Wide unsigned multiplier built by time-sharing one 4x4 vedic core over all nibble pairs.
// The helper cores (2x2 vedic cell, 8-bit ripple adder, 4x4 vedic multiplier) live here too.

module Vedic2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_s
);
  logic w_c1;

  assign w_c1   = i_a[1] & i_b[0] & i_a[0] & i_b[1];
  assign o_s[0] = i_a[0] & i_b[0];
  assign o_s[1] = (i_a[1] & i_b[0]) ^ (i_a[0] & i_b[1]);
  assign o_s[2] = (i_a[1] & i_b[1]) ^ w_c1;
  assign o_s[3] = i_a[1] & i_b[1] & w_c1;
endmodule

module FullAdder8 (
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic r_carry;

  // Bit-serial ripple chain; the carry variable threads through the loop.
  always_comb begin
    o_sum   = '0;
    r_carry = i_cin;
    for (int n = 0; n < 8; n++) begin
      o_sum[n] = i_x[n] ^ i_y[n] ^ r_carry;
      r_carry  = (i_x[n] & i_y[n]) | (r_carry & (i_x[n] ^ i_y[n]));
    end
    o_cout = r_carry;
  end
endmodule

module vedic4x4_8bitFA (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [8:0] o_s
);
  logic [3:0] w_q0, w_q1, w_q2, w_q3;
  logic [7:0] w_mid, w_hi, w_lo;
  logic       w_c1, w_c2, w_c3;

  Vedic2x2 u_q0 (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_s(w_q0));
  Vedic2x2 u_q1 (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_s(w_q1));
  Vedic2x2 u_q2 (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_s(w_q2));
  Vedic2x2 u_q3 (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_s(w_q3));

  // The two cross terms share weight 4; the high term has weight 16.
  FullAdder8 u_addMid (.i_x({2'b00, w_q1, 2'b00}), .i_y({2'b00, w_q2, 2'b00}),
                       .i_cin(1'b0), .o_sum(w_mid), .o_cout(w_c1));
  FullAdder8 u_addHi  (.i_x(w_mid), .i_y({w_q3, 4'b0000}),
                       .i_cin(1'b0), .o_sum(w_hi), .o_cout(w_c2));
  FullAdder8 u_addLo  (.i_x(w_hi), .i_y({4'b0000, w_q0}),
                       .i_cin(1'b0), .o_sum(w_lo), .o_cout(w_c3));

  assign o_s = {w_c1 | w_c2 | w_c3, w_lo};
endmodule

module vedic_seq_mul_ctrl #(
  parameter int NIB   = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  vedic_seq_mul_ctrl_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_cnt
);
  localparam int OP_W   = 4 * NIB;
  localparam int ACC_W  = 8 * NIB;
  localparam int STEPS  = NIB * NIB;
  localparam int STEP_W = $clog2(STEPS + 1);
  localparam int IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             r_state;
  logic [OP_W-1:0]    r_aReg, r_bReg;
  logic [ACC_W-1:0]   r_acc, r_p;
  logic               r_outValid, r_busy;
  logic [CNT_W-1:0]   r_doneCnt;
  logic [STEP_W-1:0]  r_step;
  logic [IDX_W-1:0]   r_aIdx, r_bIdx;

  logic [3:0]         w_aNib, w_bNib;
  logic [8:0]         w_coreS;
  logic [5:0]         w_shift;
  logic [ACC_W-1:0]   w_partial, w_accNext;
  logic               w_lastStep;

  always_comb begin
    w_aNib = '0;
    w_bNib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (r_aIdx == IDX_W'(n)) w_aNib = r_aReg[4*n +: 4];
      if (r_bIdx == IDX_W'(n)) w_bNib = r_bReg[4*n +: 4];
    end
  end

  vedic4x4_8bitFA u_core (.i_a(w_aNib), .i_b(w_bNib), .o_s(w_coreS));

  // Core bit 8 is masked off; the partial product is zero-extended before the shift.
  assign w_shift    = {4'(r_aIdx) + 4'(r_bIdx), 2'b00};
  assign w_partial  = ACC_W'(w_coreS & 9'h0FF) << w_shift;
  assign w_accNext  = r_acc + w_partial;
  assign w_lastStep = (r_step == STEP_W'(STEPS - 1));

  assign bus.in_ready  = (r_state == IDLE) & ~rst;
  assign bus.out_valid = r_outValid;
  assign bus.p         = r_p;
  assign busy          = r_busy;
  assign done_cnt      = r_doneCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_aReg     <= '0;
      r_bReg     <= '0;
      r_acc      <= '0;
      r_p        <= '0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_doneCnt  <= '0;
      r_step     <= '0;
      r_aIdx     <= '0;
      r_bIdx     <= '0;
    end else if (abort) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_acc      <= '0;
      r_step     <= '0;
      r_aIdx     <= '0;
      r_bIdx     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_aReg  <= bus.a;
            r_bReg  <= bus.b;
            r_acc   <= '0;
            r_step  <= '0;
            r_aIdx  <= '0;
            r_bIdx  <= '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_acc  <= w_accNext;
          r_step <= r_step + 1'b1;
          // a nibble index runs fastest; b advances when a wraps.
          if (r_aIdx == IDX_W'(NIB - 1)) begin
            r_aIdx <= '0;
            r_bIdx <= r_bIdx + 1'b1;
          end else begin
            r_aIdx <= r_aIdx + 1'b1;
          end
          if (w_lastStep) begin
            r_p        <= w_accNext;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
            if (r_doneCnt != '1) r_doneCnt <= r_doneCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// Directed bench for vedic_seq_mul_ctrl at NIB=2, 4 and 1 with a product scoreboard.
// Expected products come from plain multiplication of the driven operands.
module tb_vedic_seq_mul_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        abort2, abort4, abort1;
  logic        busy2, busy4, busy1;
  logic [15:0] done2, done4;
  logic [1:0]  done1;

  int          nAssert = 0;
  int          nFail   = 0;
  int          cyc     = 0;
  int          lat;
  int          expCnt2;
  int          t0, t1;
  logic [31:0] lastExp;
  logic [31:0] sbq[$];

  vedic_seq_mul_ctrl_if #(.NIB(2)) bus2 ();
  vedic_seq_mul_ctrl_if #(.NIB(4)) bus4 ();
  vedic_seq_mul_ctrl_if #(.NIB(1)) bus1 ();

  vedic_seq_mul_ctrl #(.NIB(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .abort(abort2), .bus(bus2), .busy(busy2), .done_cnt(done2));
  vedic_seq_mul_ctrl #(.NIB(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .abort(abort4), .bus(bus4), .busy(busy4), .done_cnt(done4));
  vedic_seq_mul_ctrl #(.NIB(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .abort(abort1), .bus(bus1), .busy(busy1), .done_cnt(done1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue2(input logic [7:0] ia, input logic [7:0] ib, input bit push);
    checkEq("in_ready_at_issue", 32'(bus2.in_ready), 32'd1);
    bus2.a        = ia;
    bus2.b        = ib;
    bus2.in_valid = 1'b1;
    if (push) sbq.push_back(32'(ia) * 32'(ib));
    tick();
    bus2.in_valid = 1'b0;
    lat = 1;
  endtask

  task automatic waitOut2(input string tag);
    int budget = 20;
    while (!bus2.out_valid && budget > 0) begin
      tick();
      lat++;
      budget--;
    end
    checkEq({tag, "_out_valid"}, 32'(bus2.out_valid), 32'd1);
    lastExp = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
    checkEq({tag, "_p"}, 32'(bus2.p), lastExp);
  endtask

  initial begin
    logic [3:0] opsA [4];
    logic [3:0] opsB [4];
    int budget;
    opsA = '{4'hF, 4'h7, 4'h0, 4'hF};
    opsB = '{4'hD, 4'h9, 4'hF, 4'hF};

    rst = 1'b1;
    abort2 = 1'b0; abort4 = 1'b0; abort1 = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
    expCnt2 = 0;
    tick();
    tick();

    checkEq("rst_in_ready", 32'(bus2.in_ready), 32'd0);
    checkEq("rst_out_valid", 32'(bus2.out_valid), 32'd0);
    checkEq("rst_busy", 32'(busy2), 32'd0);
    checkEq("rst_done_cnt", 32'(done2), 32'd0);
    checkEq("rst_p", 32'(bus2.p), 32'd0);
    rst = 1'b0;
    tick();
    checkEq("idle_in_ready", 32'(bus2.in_ready), 32'd1);

    // Basic product with latency and handshake timing.
    bus2.out_ready = 1'b1;
    issue2(8'hA5, 8'h3C, 1'b1);
    checkEq("t1_busy", 32'(busy2), 32'd1);
    waitOut2("t1");
    checkEq("t1_latency", 32'(lat), 32'd5);
    tick();
    expCnt2++;
    checkEq("t1_valid_drop", 32'(bus2.out_valid), 32'd0);
    checkEq("t1_done_cnt", 32'(done2), 32'(expCnt2));
    checkEq("t1_in_ready_back", 32'(bus2.in_ready), 32'd1);

    // Back-to-back operations at the minimum issue interval.
    t0 = cyc;
    issue2(8'hFF, 8'hFF, 1'b1);
    waitOut2("t2a");
    tick();
    expCnt2++;
    t1 = cyc;
    issue2(8'h00, 8'h7E, 1'b1);
    checkEq("t2_interval", 32'(t1 - t0), 32'd6);
    waitOut2("t2b");
    tick();
    expCnt2++;
    checkEq("t2_done_cnt", 32'(done2), 32'(expCnt2));

    // Backpressure: result held while operands churn.
    bus2.out_ready = 1'b0;
    issue2(8'h12, 8'h34, 1'b1);
    waitOut2("t3");
    for (int n = 0; n < 10; n++) begin
      bus2.in_valid = 1'b1;
      bus2.a = 8'($urandom);
      bus2.b = 8'($urandom);
      tick();
      checkEq("t3_hold_valid", 32'(bus2.out_valid), 32'd1);
      checkEq("t3_hold_p", 32'(bus2.p), lastExp);
      checkEq("t3_hold_in_ready", 32'(bus2.in_ready), 32'd0);
    end
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;
    tick();
    expCnt2++;
    checkEq("t3_valid_drop", 32'(bus2.out_valid), 32'd0);
    checkEq("t3_done_cnt", 32'(done2), 32'(expCnt2));

    // Abort on the second MUL edge discards the work.
    issue2(8'hFF, 8'hFF, 1'b0);
    tick();
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    checkEq("t4_abort_busy", 32'(busy2), 32'd0);
    checkEq("t4_abort_in_ready", 32'(bus2.in_ready), 32'd1);
    for (int n = 0; n < 6; n++) begin
      tick();
      checkEq("t4_no_valid", 32'(bus2.out_valid), 32'd0);
    end
    checkEq("t4_done_unchanged", 32'(done2), 32'(expCnt2));
    issue2(8'h03, 8'h05, 1'b1);
    waitOut2("t4");
    checkEq("t4_latency", 32'(lat), 32'd5);
    tick();
    expCnt2++;
    checkEq("t4_done_cnt", 32'(done2), 32'(expCnt2));

    // Abort in IDLE blocks acceptance; abort in DONE blocks the count.
    bus2.in_valid = 1'b1;
    bus2.a = 8'h11;
    bus2.b = 8'h22;
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    bus2.in_valid = 1'b0;
    checkEq("t4_idle_abort_busy", 32'(busy2), 32'd0);
    issue2(8'h21, 8'h43, 1'b1);
    waitOut2("t4c");
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    checkEq("t4c_valid", 32'(bus2.out_valid), 32'd0);
    checkEq("t4c_done_unchanged", 32'(done2), 32'(expCnt2));
    checkEq("t4c_busy", 32'(busy2), 32'd0);

    // Reset in DONE with the sink ready on the same edge.
    issue2(8'h5A, 8'h0F, 1'b1);
    waitOut2("t5");
    rst = 1'b1;
    tick();
    expCnt2 = 0;
    checkEq("t5_out_valid", 32'(bus2.out_valid), 32'd0);
    checkEq("t5_p", 32'(bus2.p), 32'd0);
    checkEq("t5_done_cnt", 32'(done2), 32'd0);
    checkEq("t5_busy", 32'(busy2), 32'd0);
    checkEq("t5_in_ready_rst", 32'(bus2.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkEq("t5_in_ready_release", 32'(bus2.in_ready), 32'd1);
    tick();

    // Random operands with random sink stalls.
    for (int n = 0; n < 8; n++) begin
      bus2.out_ready = 1'b0;
      issue2(8'($urandom), 8'($urandom), 1'b1);
      waitOut2("rnd");
      repeat ($urandom_range(0, 3)) tick();
      bus2.out_ready = 1'b1;
      tick();
      expCnt2++;
      checkEq("rnd_done_cnt", 32'(done2), 32'(expCnt2));
    end

    // NIB=4 full-scale product.
    bus4.out_ready = 1'b1;
    checkEq("n4_in_ready", 32'(bus4.in_ready), 32'd1);
    bus4.a = 16'hFFFF;
    bus4.b = 16'hFFFF;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 1;
    budget = 40;
    while (!bus4.out_valid && budget > 0) begin
      tick();
      lat++;
      budget--;
    end
    checkEq("n4_out_valid", 32'(bus4.out_valid), 32'd1);
    checkEq("n4_latency", 32'(lat), 32'd17);
    checkEq("n4_p", 32'(bus4.p), 32'hFFFE0001);
    tick();
    checkEq("n4_done_cnt", 32'(done4), 32'd1);

    // NIB=1 products, with a 2-bit counter that must saturate.
    bus1.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      bus1.a = opsA[n];
      bus1.b = opsB[n];
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      lat = 1;
      budget = 10;
      while (!bus1.out_valid && budget > 0) begin
        tick();
        lat++;
        budget--;
      end
      checkEq("n1_out_valid", 32'(bus1.out_valid), 32'd1);
      checkEq("n1_latency", 32'(lat), 32'd2);
      checkEq("n1_p", 32'(bus1.p), 32'(opsA[n]) * 32'(opsB[n]));
      tick();
      checkEq("n1_done_cnt", 32'(done1), (n < 3) ? 32'(n + 1) : 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/vedic_seq_mul_ctrl.md
Name: vedic_seq_mul_ctrl

Overview:
- Multi-cycle controller that time-shares one vedic4x4_8bitFA 4x4 multiplier core to produce a wide unsigned product.
- Operands are NIB nibbles wide. The controller steps through all NIB*NIB nibble pairs, feeds each pair to the core, and shift-accumulates the 8-bit partial products.
- Sits between a valid/ready operand source and a valid/ready result sink; one operation in flight at a time.

Parameters:
- NIB, 2, operand width in nibbles (operand width = 4*NIB, product width = 8*NIB); legal range 1..4.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- abort  input  1  synchronous flush of the current operation.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- a  input  4*NIB  multiplicand, unsigned.
- b  input  4*NIB  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  sink accepts product.
- p  output  8*NIB  product a*b.
- busy  output  1  high in MUL or DONE.
- done_cnt  output  CNT_W  count of products handed off, saturating.

Behaviour:
- One clock domain. rst is synchronous, active-high, and overrides everything.
- Reset state: IDLE. Reset values: acc=0, p=0, out_valid=0, busy=0, done_cnt=0, step=0, captured operands=0.
- in_ready = (state==IDLE) & ~rst; combinational.
- FSM states and transitions:
  - IDLE: on an edge with in_valid & in_ready, register a and b, clear acc, set step=0, go to MUL.
  - MUL: for step k, i = k mod NIB (a nibble index), j = k div NIB (b nibble index).
    - Core inputs: a_reg[4i+3:4i] and b_reg[4j+3:4j].
    - Each edge: acc <= acc + (core_s[7:0] << 4*(i+j)); step <= k+1.
    - Core bit s[8] is ignored (always 0 for a 4x4 product).
    - After the edge processing k = NIB*NIB-1, go to DONE.
  - DONE: p holds acc and out_valid=1. On an edge with out_valid & out_ready, go to IDLE, out_valid<=0, done_cnt<=done_cnt+1 (saturates at all-ones, no wrap).
- Arithmetic: acc is 8*NIB bits and never overflows, since the max is (2^(4N)-1)^2 < 2^(8N). Partial products are zero-extended before shifting.
- Latency: out_valid rises NIB*NIB+1 edges after the accepting edge (NIB=2: 5 edges).
- Minimum issue interval: NIB*NIB+2 cycles; the next in_ready appears the cycle after output handshake.
- Backpressure: in DONE with out_ready=0, p and out_valid are held stable indefinitely. Input changes are ignored.
- Operands are sampled only at the accepting edge. Changes to a/b during MUL or DONE have no effect.
- p is stable from DONE entry until the handshake. After returning to IDLE, p retains its last value; only out_valid qualifies it.
- abort (priority below rst):
  - At the next edge: state<=IDLE, out_valid<=0, acc<=0, step<=0.
  - No done_cnt increment, even if out_ready is high on the same edge.
  - abort in IDLE with in_valid high: nothing is accepted that edge.
- rst or abort mid-MUL discards partial results. The next operation starts clean.
- busy = (state!=IDLE).

Test Plan:
- NIB=2, a=8'hA5, b=8'h3C, out_ready=1 -> out_valid after 5 edges, p=16'h26AC, done_cnt=1, in_ready high again one cycle after the handshake.
- NIB=2, a=8'hFF, b=8'hFF, then a=8'h00, b=8'h7E back-to-back -> p=16'hFE01, then p=16'h0000; issue interval 6 cycles; done_cnt=2.
- NIB=2, a=8'h12, b=8'h34, out_ready held 0 for 10 cycles -> p=16'h03A8 and out_valid stable the whole time; in_ready=0; a/b toggling has no effect; completes when out_ready=1.
- NIB=2, a=8'hFF, b=8'hFF, abort pulsed at the 2nd MUL edge -> IDLE next cycle, out_valid never asserts, done_cnt unchanged. A following a=8'h03, b=8'h05 gives p=16'h000F.
- NIB=2, rst asserted in DONE with out_ready=1 on the same edge -> out_valid=0, p=0, done_cnt=0, in_ready=0 while rst is high.
- NIB=4, a=16'hFFFF, b=16'hFFFF -> out_valid after 17 edges, p=32'hFFFE0001. NIB=1, a=4'hF, b=4'hD -> p=8'hC3 after 2 edges.
